// File: rtl/seq_gen_1011.sv
// seq_gen_1011: serial frame transmitter for the 1011 link.
// A word taken over a valid/ready handshake is sent as the preamble 1,0,1,1,
// then the payload MSB first, then one idle gap cycle that carries frame_done.
module seq_gen_1011 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    // The counter must hold both the preamble index (3) and the payload index (DATA_W-1).
    localparam int CNT_MAX = (DATA_W > 4) ? DATA_W : 4;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [3:0]       PREAMBLE      = 4'b1011;
    localparam logic [CNT_W-1:0] PRE_FIRST_IDX = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST_IDX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_bit_q, out_bit_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic [1:0]        pre_idx;

    // Ready only in IDLE and never while reset is asserted.
    assign data_ready = (state_q == S_IDLE) && reset;
    assign accept     = data_valid && data_ready;

    // cnt_q holds the index of the bit currently on out_bit, so the next
    // preamble bit lives one position below it.
    assign pre_idx    = cnt_q[1:0] - 2'd1;

    assign out_bit    = out_bit_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_GAP);

    // Next-state and next-output logic; outputs are prepared one cycle ahead
    // so out_bit/out_valid come straight from flops.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_PRE;
                    sh_d        = data_in;
                    cnt_d       = PRE_FIRST_IDX;
                    out_bit_d   = PREAMBLE[3];
                    out_valid_d = 1'b1;
                end
            end
            S_PRE: begin
                out_valid_d = 1'b1;
                if (cnt_q == '0) begin
                    // Last preamble bit on the wire: line up the payload MSB.
                    state_d   = S_DATA;
                    out_bit_d = sh_q[DATA_W-1];
                    sh_d      = sh_q << 1;
                    cnt_d     = DATA_LAST_IDX;
                end else begin
                    out_bit_d = PREAMBLE[pre_idx];
                    cnt_d     = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    out_valid_d = 1'b1;
                    out_bit_d   = sh_q[DATA_W-1];
                    sh_d        = sh_q << 1;
                    cnt_d       = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sh_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_seq_gen_1011.sv
// Bench for seq_gen_1011: a frame-queue reference model checks every cycle,
// plus directed checks and a 1011 detector on a DATA_W=4 instance.
module tb_seq_gen_1011;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  data_in;
    logic          data_valid;
    logic          data_ready, out_bit, out_valid, busy, frame_done;

    logic [W4-1:0] data_in4;
    logic          data_valid4;
    logic          data_ready4, out_bit4, out_valid4, busy4, frame_done4;

    int vec = 0;
    int err = 0;

    seq_gen_1011 #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .out_bit(out_bit), .out_valid(out_valid),
        .busy(busy), .frame_done(frame_done)
    );

    seq_gen_1011 #(.DATA_W(W4)) dut4 (
        .clk(clk), .reset(reset), .data_in(data_in4), .data_valid(data_valid4),
        .data_ready(data_ready4), .out_bit(out_bit4), .out_valid(out_valid4),
        .busy(busy4), .frame_done(frame_done4)
    );

    always #5 clk = ~clk;

    // Loopback receiver: overlapping 1011 detector on the raw DATA_W=4 line.
    logic [3:0] det_sr  = 4'b0000;
    int         det_cnt = 0;
    int         fd4_cnt = 0;
    always @(negedge clk) begin
        det_sr <= {det_sr[2:0], out_bit4};
        if ({det_sr[2:0], out_bit4} == 4'b1011) det_cnt <= det_cnt + 1;
        if (frame_done4 === 1'b1) fd4_cnt <= fd4_cnt + 1;
    end

    // Reference model: each accepted word expands into the list of cycles it
    // will occupy on the wire; the DUT must replay that list one entry per cycle.
    typedef struct packed {
        logic b;
        logic v;
        logic d;
        logic bz;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;

    function automatic exp_t mk(input logic b, input logic v, input logic d);
        exp_t e;
        e.b = b; e.v = v; e.d = d; e.bz = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0] pre;
        pre = 4'b1011;
        @(posedge clk);
        if (!reset) begin
            q.delete();
            cur = '0;
        end else begin
            if (!cur.bz && data_valid) begin
                for (int i = 3; i >= 0; i--) q.push_back(mk(pre[i], 1'b1, 1'b0));
                for (int i = W - 1; i >= 0; i--) q.push_back(mk(data_in[i], 1'b1, 1'b0));
                q.push_back(mk(1'b0, 1'b0, 1'b1));
            end
            cur = (q.size() > 0) ? q.pop_front() : exp_t'('0);
        end
        #1;
        chk("out_bit",    out_bit,    cur.b);
        chk("out_valid",  out_valid,  cur.v);
        chk("frame_done", frame_done, cur.d);
        chk("busy",       busy,       cur.bz);
        chk("data_ready", data_ready, !cur.bz && reset);
    endtask

    initial begin
        logic [11:0] seq;
        logic [7:0]  pay;
        int          done_cnt;
        int          d0, f0;

        reset = 1'b0; data_valid = 1'b1; data_in = 8'h55;
        data_valid4 = 1'b0; data_in4 = '0;

        // Reset held with valid high: nothing may be accepted.
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        reset = 1'b1; data_valid = 1'b0;
        #1;
        chk("rdy_release", data_ready, 1);

        // Single 0xA5 frame.
        data_in = 8'hA5; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        seq = {11'b0, out_bit};
        for (int i = 2; i <= 12; i++) begin
            step();
            seq = {seq[10:0], out_bit};
        end
        chk("a5_stream", seq, 12'hBA5);
        step();
        chk("a5_done", frame_done, 1);
        chk("a5_gap_ov", out_valid, 0);
        step();
        chk("a5_ready", data_ready, 1);

        // Back-to-back with valid held: 0xFF then 0x00.
        data_in = 8'hFF; data_valid = 1'b1; done_cnt = 0; pay = '0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 14) chk("b2b_idle", out_valid, 0);
            if (i == 15) chk("b2b_pre2", {out_valid, out_bit}, 2'b11);
            if (i >= 19 && i <= 26) pay = {pay[6:0], out_bit};
            if (frame_done === 1'b1) done_cnt++;
            if (i == 5) data_in = 8'h00;
            if (i == 20) data_valid = 1'b0;
        end
        chk("b2b_pay2", pay, 8'h00);
        chk("b2b_dones", done_cnt, 2);

        // Inputs disturbed while a 0x81 frame is in flight.
        data_in = 8'h81; data_valid = 1'b1;
        step();
        data_in = 8'h3C; pay = '0;
        for (int i = 2; i <= 12; i++) begin
            data_valid = i[0];
            step();
            if (i >= 5) pay = {pay[6:0], out_bit};
        end
        chk("busy_pay", pay, 8'h81);
        data_valid = 1'b1;
        step();
        chk("busy_gap_done", frame_done, 1);
        data_valid = 1'b0;
        step();
        chk("busy_idle", busy, 0);

        // Reset during payload bit 3 of 0xC3.
        data_in = 8'hC3; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 2; i <= 9; i++) step();
        chk("mid_bit3", {out_valid, out_bit}, 2'b10);
        reset = 1'b0;
        step();
        chk("mid_ov", out_valid, 0);
        chk("mid_busy", busy, 0);
        reset = 1'b1; done_cnt = 0;
        repeat (12) begin
            step();
            if (frame_done === 1'b1) done_cnt++;
        end
        chk("mid_no_done", done_cnt, 0);
        data_in = 8'h5A; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        seq = {11'b0, out_bit};
        for (int i = 2; i <= 12; i++) begin
            step();
            seq = {seq[10:0], out_bit};
        end
        chk("post_rst_stream", seq, 12'hB5A);
        repeat (2) step();

        // Loopback on the DATA_W=4 instance: frames 0x0 then 0xB.
        d0 = det_cnt; f0 = fd4_cnt;
        data_in4 = 4'h0; data_valid4 = 1'b1;
        step();
        data_valid4 = 1'b0;
        repeat (11) step();
        data_in4 = 4'hB; data_valid4 = 1'b1;
        step();
        data_valid4 = 1'b0;
        repeat (12) step();
        chk("loop_detects", det_cnt - d0, 3);
        chk("loop_dones", fd4_cnt - f0, 2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 49) != 0);
            data_valid = ($urandom_range(0, 3) != 0);
            data_in    = 8'($urandom);
            step();
        end
        reset = 1'b1; data_valid = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/seq_gen_1011.md
# seq_gen_1011

Serial frame transmitter: the transmit side of the 1011 serial link. It accepts a DATA_W-bit word through a valid/ready handshake and emits a single-bit stream, one bit per clock. Each frame is the preamble 1,0,1,1, then the payload MSB first, then one idle gap cycle. A downstream 1011 detector sampling `out_bit` locks onto the preamble.

## Interface
- DATA_W, 8, payload width in bits; legal range 1..32.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- data_in  input  DATA_W  payload word; sampled only on handshake.
- data_valid  input  1  producer has a word on data_in.
- data_ready  output  1  block can accept a word this cycle.
- out_bit  output  1  serial bit, registered.
- out_valid  output  1  out_bit carries a frame bit (preamble or payload), registered.
- busy  output  1  a frame is in progress: state other than IDLE.
- frame_done  output  1  one-cycle pulse in the gap cycle after the last payload bit.

## Operation
- States:
  - IDLE
  - PRE: 4 cycles, bit index 3..0
  - DATA: DATA_W cycles, bit index DATA_W-1..0
  - GAP: 1 cycle
- Datapath: shift register of width DATA_W, plus a bit counter of width clog2(max(DATA_W,4))+1.
- Handshake:
  - data_ready = (state == IDLE) AND reset. It is combinational from state and the reset pin.
  - Accept occurs when data_valid AND data_ready are high at a rising edge.
  - On accept, data_in is latched into the shift register and the state moves to PRE.
  - data_in and data_valid are ignored in every other cycle. No queuing, no error flag.
- PRE: out_bit presents 1, 0, 1, 1 on successive cycles with out_valid = 1. After the 4th bit the state moves to DATA.
- DATA: out_bit = shift register MSB with out_valid = 1. The register shifts left one bit per cycle. After DATA_W bits the state moves to GAP.
- GAP: out_bit = 0, out_valid = 0, frame_done = 1, busy = 1. The next state is always IDLE.
- IDLE: out_bit = 0, out_valid = 0, busy = 0, frame_done = 0.
- Payload is not bit-stuffed. A 1011 pattern inside the payload is legal and is the receiver's concern.
- Unused state encodings return to IDLE on the next edge with all outputs at IDLE values.

## Timing
- Reset (reset = 0 at an edge):
  - Next-cycle values: state IDLE, out_bit 0, out_valid 0, busy 0, frame_done 0, counter 0, shift register 0.
  - data_ready is 0 in any cycle where reset is 0.
  - Reset takes priority over every other event.
- Latency: accept at edge T gives the first preamble bit valid in cycle T+1.
  - Preamble occupies cycles T+1..T+4.
  - Payload bit DATA_W-1-k appears in cycle T+5+k.
  - Gap and frame_done occur in cycle T+5+DATA_W.
  - IDLE and data_ready = 1 return in cycle T+6+DATA_W.
- Throughput: the minimum frame period is DATA_W+6 cycles. A back-to-back accept in the first IDLE cycle gives the next preamble at T+7+DATA_W.
- Reset mid-frame, in any state:
  - The frame is abandoned with no frame_done pulse.
  - The outputs take reset values on the next cycle.
  - The word is lost.
- frame_done is exactly one cycle wide, once per completed frame.
- Simultaneous events:
  - data_valid held high through a frame produces exactly one accept per IDLE cycle.
  - A word changed on data_in mid-frame does not affect the frame in flight.

## Test plan
- Reset: hold reset = 0 for 3 cycles with data_valid = 1. Required: data_ready = 0, out_valid = 0, out_bit = 0, busy = 0, no accept. After release, data_ready = 1 in the first cycle.
- Single frame, DATA_W = 8, data_in = 0xA5 accepted at T. Required:
  - out_bit 1,0,1,1,1,0,1,0,0,1,0,1 over T+1..T+12 with out_valid = 1.
  - Cycle T+13: out_valid = 0 and frame_done = 1.
  - Cycle T+14: data_ready = 1.
- Back-to-back: data_valid held high with 0xFF then 0x00. Required:
  - The second preamble starts at T+15.
  - The second payload is eight 0s.
  - Exactly 2 frame_done pulses.
- Busy-time stimulus: change data_in to 0x3C and toggle data_valid during PRE/DATA of a 0x81 frame. Required: the payload sent is 1,0,0,0,0,0,0,1 and there is no second accept until IDLE.
- Reset mid-payload: drive reset = 0 for 1 cycle at payload bit 3 of 0xC3. Required:
  - Next cycle: out_valid = 0 and busy = 0.
  - No frame_done pulse.
  - A new frame sent afterwards is correct.
- Loopback: drive out_bit into a 1011 detector model with frames 0x00, 0x0B and DATA_W = 4. Required: a detection pulse following each preamble, plus one after the embedded 1011 payload of 0x0B.
